// File: rtl/rnbip_pkg.sv
// ---------------------------------------------------------------------------
// rnbip_pkg
// Shared definitions for the RNBIP-2 CALL/RET path: the controller state
// encoding, default address/data widths, and the read/write code used by the
// stack-pointer block's rw input.
// ---------------------------------------------------------------------------
package rnbip_pkg;

    // Default widths: stack address from the stack-pointer block, stored PC.
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    // Controller state encoding, kept as plain constants so legacy tools and
    // waveform scripts that match on raw values keep working.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PUSH   = 3'd1;
    localparam logic [2:0] ST_POP    = 3'd2;
    localparam logic [2:0] ST_POP_RD = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Stack-pointer rw code: 0 moves the pointer up, 1 moves it down.
    localparam logic STK_PUSH = 1'b0;
    localparam logic STK_POP  = 1'b1;

    // True in the two states that move the stack pointer.
    function automatic logic stk_active(input logic [2:0] state);
        return (state == ST_PUSH) || (state == ST_POP);
    endfunction

endpackage : rnbip_pkg

// File: rtl/call_ret_ctrl_ret_ram.sv
// ---------------------------------------------------------------------------
// ret_ram
// Return-address storage: 2**AW entries of DW bits, one synchronous write
// port and one combinational read port.
//
// Ports:
//   clk      in   clock, rising edge
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address
//   rdata_o  out  read data (combinational from raddr_i)
// ---------------------------------------------------------------------------
module ret_ram
    import rnbip_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    // NOTE: the array has no reset branch on purpose; resetting a RAM turns it
    // into a flop bank, and every entry is written by a PUSH before any POP
    // can read it back.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : ret_ram

// File: rtl/call_ret_ctrl.sv
// ---------------------------------------------------------------------------
// call_ret_ctrl
// CALL/RET sequencer for the RNBIP-2 core. Drives the external stack-pointer
// block (en/rw), writes the return PC into ret_ram at the pointer's next-free
// slot on CALL, and reads it back from the decremented slot on RET. A live
// entry count lets it refuse overflow/underflow without touching the stack.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   req_call  in   CALL request (sampled in IDLE only)
//   req_ret   in   RET request  (sampled in IDLE only)
//   pc_in     in   return address to push, captured with req_call
//   stk_addr  in   next-free slot from the stack-pointer block
//   stk_en    out  stack-pointer enable, one cycle per move
//   stk_rw    out  STK_PUSH / STK_POP
//   ret_pc    out  last successfully popped return address
//   done      out  one-cycle completion pulse
//   err_ovf   out  CALL refused (stack full), meaningful with done
//   err_unf   out  RET refused (stack empty), meaningful with done
//   busy      out  controller not in IDLE
//   count     out  number of live entries
// ---------------------------------------------------------------------------
module call_ret_ctrl
    import rnbip_pkg::*;
#(
    parameter  int AW    = AW_DEF,
    parameter  int DW    = DW_DEF,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_call,
    input  logic          req_ret,
    input  logic [DW-1:0] pc_in,
    input  logic [AW-1:0] stk_addr,
    output logic          stk_en,
    output logic          stk_rw,
    output logic [DW-1:0] ret_pc,
    output logic          done,
    output logic          err_ovf,
    output logic          err_unf,
    output logic          busy,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [2:0]    state_q,   state_d;
    logic [CW-1:0] count_q,   count_d;
    logic [DW-1:0] pc_lat_q,  pc_lat_d;
    logic [DW-1:0] ret_pc_q,  ret_pc_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_unf_q, err_unf_d;

    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal written below gets a default first, so no path through
    // the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pc_lat_d  = pc_lat_q;
        ret_pc_d  = ret_pc_q;
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;

        unique case (state_q)
            ST_IDLE: begin
                // Error flags live until the next accepted request; CALL has
                // priority when both requests are raised together.
                if (req_call) begin
                    err_ovf_d = 1'b0;
                    err_unf_d = 1'b0;
                    if (count_q == DEPTH_C) begin
                        err_ovf_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        pc_lat_d  = pc_in;
                        state_d   = ST_PUSH;
                    end
                end else if (req_ret) begin
                    err_ovf_d = 1'b0;
                    err_unf_d = 1'b0;
                    if (count_q == '0) begin
                        err_unf_d = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        state_d   = ST_POP;
                    end
                end
            end

            ST_PUSH: begin
                // The RAM write and the pointer increment share this edge.
                count_d = count_q + ONE_C;
                state_d = ST_DONE;
            end

            ST_POP: begin
                // Pointer decrements at this edge; the read waits one cycle so
                // it sees the decremented address.
                count_d = count_q - ONE_C;
                state_d = ST_POP_RD;
            end

            ST_POP_RD: begin
                ret_pc_d = ram_rdata;
                state_d  = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: non-blocking assignments keep every register sampling the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            pc_lat_q  <= '0;
            ret_pc_q  <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pc_lat_q  <= pc_lat_d;
            ret_pc_q  <= ret_pc_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    // -----------------------------------------------------------------------
    // Return-address RAM: written and read at the pointer's current value.
    // -----------------------------------------------------------------------
    assign ram_we = (state_q == ST_PUSH);

    ret_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (stk_addr),
        .wdata_i (pc_lat_q),
        .raddr_i (stk_addr),
        .rdata_o (ram_rdata)
    );

    // -----------------------------------------------------------------------
    // Moore decodes and registered outputs
    // -----------------------------------------------------------------------
    assign stk_en  = stk_active(state_q);
    assign stk_rw  = (state_q == ST_POP) ? STK_POP : STK_PUSH;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);
    assign ret_pc  = ret_pc_q;
    assign err_ovf = err_ovf_q;
    assign err_unf = err_unf_q;
    assign count   = count_q;

endmodule : call_ret_ctrl

// File: tb/tb_call_ret_ctrl.sv
// ---------------------------------------------------------------------------
// tb_call_ret_ctrl
// Self-checking bench for call_ret_ctrl. A behavioural stack-pointer block
// sits next to the DUT; expectations come from a fixed vector table, a few
// hand-written sequences and a LIFO queue model for random traffic.
// ---------------------------------------------------------------------------
module tb_call_ret_ctrl;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          req_call;
    logic          req_ret;
    logic [DW-1:0] pc_in;
    logic [AW-1:0] stk_addr;
    logic          stk_en;
    logic          stk_rw;
    logic [DW-1:0] ret_pc;
    logic          done;
    logic          err_ovf;
    logic          err_unf;
    logic          busy;
    logic [CW-1:0] count;

    call_ret_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_call (req_call),
        .req_ret  (req_ret),
        .pc_in    (pc_in),
        .stk_addr (stk_addr),
        .stk_en   (stk_en),
        .stk_rw   (stk_rw),
        .ret_pc   (ret_pc),
        .done     (done),
        .err_ovf  (err_ovf),
        .err_unf  (err_unf),
        .busy     (busy),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Stack-pointer block: next-free-slot pointer, reset with the controller.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        stk_addr <= '0;
        else if (stk_en) stk_addr <= stk_rw ? stk_addr - 8'd1 : stk_addr + 8'd1;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Observations from the last operation.
    int          g_lat, g_en, g_rw;
    logic        g_done, g_eo, g_eu;
    logic [7:0]  g_rp;

    // Raise the request(s) at a falling edge, hold until done, count cycles
    // (first rising edge is the one that samples the request).
    task automatic run_op(input logic call, input logic ret, input logic [7:0] pc);
        @(negedge clk);
        req_call = call;
        req_ret  = ret;
        pc_in    = pc;
        g_lat = 0; g_en = 0; g_rw = 0; g_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            g_lat++;
            if (stk_en) g_en++;
            if (stk_en && stk_rw) g_rw++;
            if (done) begin
                g_done = 1'b1;
                break;
            end
        end
        g_eo = err_ovf;
        g_eu = err_unf;
        g_rp = ret_pc;
        req_call = 1'b0;
        req_ret  = 1'b0;
    endtask

    task automatic check_op(input string tag, input int lat, input int en, input int rw,
                            input logic eo, input logic eu, input logic [7:0] rp, input int cnt);
        check({tag, " done_seen"}, g_done, 1);
        check({tag, " latency"},   g_lat, lat);
        check({tag, " stk_en_cycles"}, g_en, en);
        check({tag, " pop_cycles"}, g_rw, rw);
        check({tag, " err_ovf"},   g_eo, eo);
        check({tag, " err_unf"},   g_eu, eu);
        check({tag, " ret_pc"},    g_rp, rp);
        check({tag, " count"},     count, cnt);
        check({tag, " stk_addr"},  stk_addr, cnt);
    endtask

    // Reference model: a LIFO of pushed PCs plus the last popped value.
    logic [7:0] mq[$];
    logic [7:0] last_ret = 8'h00;

    task automatic model_op(input logic call, input logic ret, input logic [7:0] pc, input string tag);
        int lat, en, rw;
        logic eo, eu;
        lat = 1; en = 0; rw = 0; eo = 1'b0; eu = 1'b0;
        if (call) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(pc);
                lat = 2; en = 1;
            end else begin
                eo = 1'b1;
            end
        end else if (ret) begin
            if (mq.size() > 0) begin
                last_ret = mq.pop_back();
                lat = 3; en = 1; rw = 1;
            end else begin
                eu = 1'b1;
            end
        end
        run_op(call, ret, pc);
        check_op(tag, lat, en, rw, eo, eu, last_ret, mq.size());
    endtask

    typedef struct {
        logic       call;
        logic       ret;
        logic [7:0] pc;
        int         lat;
        int         en;
        int         rw;
        logic       eo;
        logic       eu;
        logic [7:0] rp;
        int         cnt;
    } vec_t;

    vec_t vecs[9];

    initial begin
        // Directed table: basic CALL/RET, LIFO order, underflow, CALL priority.
        vecs[0] = '{1'b1, 1'b0, 8'h12, 2, 1, 0, 1'b0, 1'b0, 8'h00, 1};
        vecs[1] = '{1'b1, 1'b0, 8'h34, 2, 1, 0, 1'b0, 1'b0, 8'h00, 2};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 3, 1, 1, 1'b0, 1'b0, 8'h34, 1};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 3, 1, 1, 1'b0, 1'b0, 8'h12, 0};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 1, 0, 0, 1'b0, 1'b1, 8'h12, 0};
        vecs[5] = '{1'b1, 1'b0, 8'h77, 2, 1, 0, 1'b0, 1'b0, 8'h12, 1};
        vecs[6] = '{1'b1, 1'b1, 8'h88, 2, 1, 0, 1'b0, 1'b0, 8'h12, 2};
        vecs[7] = '{1'b0, 1'b1, 8'h00, 3, 1, 1, 1'b0, 1'b0, 8'h88, 1};
        vecs[8] = '{1'b0, 1'b1, 8'h00, 3, 1, 1, 1'b0, 1'b0, 8'h77, 0};

        rst = 1'b0; req_call = 1'b0; req_ret = 1'b0; pc_in = '0;
        repeat (2) @(negedge clk);
        check("rst state_outputs", {stk_en, stk_rw, done, err_ovf, err_unf, busy}, 0);
        check("rst ret_pc", ret_pc, 0);
        check("rst count", count, 0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].call, vecs[i].ret, vecs[i].pc);
            check_op($sformatf("vec%0d", i), vecs[i].lat, vecs[i].en, vecs[i].rw,
                     vecs[i].eo, vecs[i].eu, vecs[i].rp, vecs[i].cnt);
        end
        last_ret = 8'h77;

        // Fill to DEPTH, refuse one more, then drain and verify LIFO order.
        for (int i = 0; i < DEPTH; i++) model_op(1'b1, 1'b0, 8'(i), $sformatf("fill%0d", i));
        model_op(1'b1, 1'b0, 8'hEE, "ovf");
        check("ovf stk_addr", stk_addr, 8'h10);
        for (int i = 0; i < DEPTH; i++) model_op(1'b0, 1'b1, 8'h00, $sformatf("drain%0d", i));

        // A RET pulsed while a CALL is in flight is dropped.
        model_op(1'b1, 1'b0, 8'h3C, "pre_busy");
        @(negedge clk);
        req_call = 1'b1; pc_in = 8'h5A;
        @(negedge clk);
        check("busy during call", busy, 1);
        req_ret = 1'b1;
        @(negedge clk);
        check("busy call done", done, 1);
        req_ret = 1'b0; req_call = 1'b0;
        mq.push_back(8'h5A);
        repeat (3) @(negedge clk);
        check("busy ret ignored count", count, mq.size());
        check("busy idle after", busy, 0);

        // Reset while in POP: everything clears at once, stack restarts.
        @(negedge clk);
        req_ret = 1'b1;
        @(negedge clk);
        check("pop stk_en before rst", {stk_en, stk_rw}, 2'b11);
        rst = 1'b0; req_ret = 1'b0;
        #1;
        check("rst_mid outputs", {stk_en, stk_rw, done, err_ovf, err_unf, busy}, 0);
        check("rst_mid ret_pc", ret_pc, 0);
        check("rst_mid count", count, 0);
        check("rst_mid stk_addr", stk_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        mq.delete();
        last_ret = 8'h00;
        model_op(1'b1, 1'b0, 8'h55, "post_rst_call");
        model_op(1'b0, 1'b1, 8'h00, "post_rst_ret");

        // Random traffic: call-heavy first half, ret-heavy second half.
        for (int i = 0; i < 300; i++) begin
            int r, thr;
            thr = (i < 150) ? 70 : 35;
            r = $urandom_range(0, 99);
            model_op(r < thr, r >= thr - 10, 8'($urandom), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_call_ret_ctrl
